// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: opcodes, FSM states,
// divider-missing guard default and a small magnitude helper.
package hilo_muldiv_ctrl_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_DIV   = 3'd1;
   localparam logic [2:0] OP_DIVU  = 3'd2;
   localparam logic [2:0] OP_MULT  = 3'd3;
   localparam logic [2:0] OP_MULTU = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int unsigned WAIT_LIMIT_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   // 0x80000000 maps onto itself, which is the correct unsigned magnitude
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage and divider-side signals of the HI/LO controller.
// slave = controller view, master = pipeline/divider view.
interface hilo_muldiv_ctrl_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_start;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_busy;

   modport slave (
      input  op_valid, op, rs_val, rt_val, div_q, div_r, div_busy,
      output stall, hi, lo, div_start, div_dividend, div_divisor
   );

   modport master (
      output op_valid, op, rs_val, rt_val, div_q, div_r, div_busy,
      input  stall, hi, lo, div_start, div_dividend, div_divisor
   );
endinterface

// File: rtl/hilo_muldiv_ctrl_div_sign_fix.sv
// Signed post-fixup of an unsigned divide: quotient negated when operand signs differ,
// remainder takes the sign of the dividend.
module hilo_muldiv_ctrl_div_sign_fix (
   input  logic        is_signed_i,
   input  logic        sa_i,
   input  logic        sb_i,
   input  logic [31:0] uq_i,
   input  logic [31:0] ur_i,
   output logic [31:0] q_o,
   output logic [31:0] r_o
);

   logic neg_q;
   logic neg_r;

   assign neg_q = is_signed_i & (sa_i ^ sb_i);
   assign neg_r = is_signed_i & sa_i;

   assign q_o = neg_q ? (~uq_i + 32'd1) : uq_i;
   assign r_o = neg_r ? (~ur_i + 32'd1) : ur_i;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage HI/LO controller: single-cycle MULT/MULTU/MTHI/MTLO, and DIV/DIVU through
// an external 32-cycle unsigned divider while stalling the pipeline.
//
//  state      | meaning
//  IDLE       | accept ops; multiply/move complete here, divide latches operands
//  START      | one-cycle div_start pulse
//  WAIT_BUSY  | wait for divider busy; give up after WAIT_LIMIT cycles
//  RUN        | divider iterating; capture fixed-up q/r when busy drops
//  DONE       | write HI/LO, op retires
module hilo_muldiv_ctrl
   import hilo_muldiv_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEF
) (
   input  logic             clock_i,
   input  logic             reset_i,
   hilo_muldiv_ctrl_if.slave bus
);

   localparam int unsigned CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   state_e         state_q, state_d;
   logic [31:0]    hi_q, hi_d;
   logic [31:0]    lo_q, lo_d;
   logic [31:0]    dvd_q, dvd_d;
   logic [31:0]    dvs_q, dvs_d;
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
   logic           signed_q, signed_d;
   logic [31:0]    quot_q, quot_d;
   logic [31:0]    rem_q, rem_d;
   logic [CW-1:0]  wait_cnt_q, wait_cnt_d;

   logic           div_req;
   logic           op_signed;
   logic [63:0]    prod_s;
   logic [63:0]    prod_u;
   logic [31:0]    fix_q;
   logic [31:0]    fix_r;

   assign div_req   = bus.op_valid & ((bus.op == OP_DIV) | (bus.op == OP_DIVU));
   assign op_signed = (bus.op == OP_DIV);

   assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val})
                 * $signed({{32{bus.rt_val[31]}}, bus.rt_val});
   assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

   hilo_muldiv_ctrl_div_sign_fix u_sign_fix (
      .is_signed_i (signed_q),
      .sa_i        (sa_q),
      .sb_i        (sb_q),
      .uq_i        (bus.div_q),
      .ur_i        (bus.div_r),
      .q_o         (fix_q),
      .r_o         (fix_r)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (div_req) state_d = ST_START;
         ST_START:     state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (bus.div_busy)          state_d = ST_RUN;
            else if (wait_cnt_q == '0) state_d = ST_IDLE;
         end
         ST_RUN:       if (!bus.div_busy) state_d = ST_DONE;
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.div_start = (state_q == ST_START);
      bus.stall     = ((state_q == ST_IDLE) & div_req)
                    | (state_q == ST_START)
                    | (state_q == ST_WAIT_BUSY)
                    | (state_q == ST_RUN);
   end

   always_comb begin
      hi_d       = hi_q;
      lo_d       = lo_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      signed_d   = signed_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.op_valid) begin
               unique case (bus.op)
                  OP_DIV, OP_DIVU: begin
                     dvd_d    = op_signed ? abs32(bus.rs_val) : bus.rs_val;
                     dvs_d    = op_signed ? abs32(bus.rt_val) : bus.rt_val;
                     sa_d     = op_signed & bus.rs_val[31];
                     sb_d     = op_signed & bus.rt_val[31];
                     signed_d = op_signed;
                  end
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_MTHI:  hi_d = bus.rs_val;
                  OP_MTLO:  lo_d = bus.rs_val;
                  default: ;
               endcase
            end
         end
         ST_START: wait_cnt_d = CW'(WAIT_LIMIT - 1);
         ST_WAIT_BUSY: begin
            if (!bus.div_busy && (wait_cnt_q != '0)) wait_cnt_d = wait_cnt_q - 1'b1;
         end
         ST_RUN: begin
            if (!bus.div_busy) begin
               quot_d = fix_q;
               rem_d  = fix_r;
            end
         end
         ST_DONE: begin
            hi_d = rem_q;
            lo_d = quot_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hi_q       <= '0;
         lo_q       <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         signed_q   <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         wait_cnt_q <= '0;
      end else begin
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         signed_q   <= signed_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
   assign bus.div_dividend = dvd_q;
   assign bus.div_divisor  = dvs_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with a behavioural 32-cycle unsigned divider.
module tb_hilo_muldiv_ctrl;
   import hilo_muldiv_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_mis;
   int   start_cnt;
   logic start_lat;
   logic div_en;
   int   dcnt;

   hilo_muldiv_ctrl_if bus ();

   hilo_muldiv_ctrl dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // divider model: start sampled on the falling edge, busy for 32 rising edges
   always @(negedge clk) begin
      start_lat <= bus.div_start;
      if (bus.div_start === 1'b1) start_cnt <= start_cnt + 1;
   end

   always @(posedge clk) begin
      if (rst) begin
         bus.div_busy <= 1'b0;
         bus.div_q    <= '0;
         bus.div_r    <= '0;
         dcnt         <= 0;
      end else if (start_lat === 1'b1 && div_en) begin
         bus.div_busy <= 1'b1;
         dcnt         <= 32;
      end else if (bus.div_busy) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) begin
            bus.div_busy <= 1'b0;
            if (bus.div_divisor == 32'd0) begin
               bus.div_q <= 32'hFFFF_FFFF;
               bus.div_r <= bus.div_dividend;
            end else begin
               bus.div_q <= bus.div_dividend / bus.div_divisor;
               bus.div_r <= bus.div_dividend % bus.div_divisor;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // mode: 0 normal, 1 foreign op injected mid-run, 2 drop op after 6 cycles, 3 reset at cycle 10
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int mode, output int stalls, output int starts);
      int  s0;
      bit  done;
      @(posedge clk);
      #1;
      bus.op_valid = 1'b1;
      bus.op       = o;
      bus.rs_val   = a;
      bus.rt_val   = b;
      s0     = start_cnt;
      stalls = 0;
      done   = 0;
      for (int n = 1; n <= 100 && !done; n++) begin
         @(negedge clk);
         if (bus.stall === 1'b1) stalls++;
         if (mode == 1 && n == 10) begin
            bus.op     = OP_MTHI;
            bus.rs_val = 32'h1234_5678;
         end
         if (mode == 1 && n == 15) begin
            bus.op     = o;
            bus.rs_val = a;
         end
         if (mode == 2 && n == 6) begin
            bus.op_valid = 1'b0;
            done = 1;
         end else if (mode == 3 && n == 10) begin
            bus.op_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            done = 1;
         end else if (bus.stall === 1'b0) begin
            done = 1;
         end
      end
      check("op_completed", {31'd0, done}, 32'd1);
      if (mode != 3) begin
         @(posedge clk);
         #1;
         bus.op_valid = 1'b0;
      end
      starts = start_cnt - s0;
   endtask

   initial begin
      int st;
      int sc;
      n_cmp = 0;
      n_mis = 0;
      start_cnt = 0;
      div_en = 1'b1;
      rst = 1'b1;
      bus.op_valid = 1'b0;
      bus.op       = OP_NOP;
      bus.rs_val   = '0;
      bus.rt_val   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_stall", {31'd0, bus.stall}, 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_start", {31'd0, bus.div_start}, 32'd0);
      check("rst_dividend", bus.div_dividend, 32'd0);
      check("rst_divisor", bus.div_divisor, 32'd0);

      run_op(OP_DIVU, 32'd100, 32'd7, 0, st, sc);
      @(negedge clk);
      check("divu100_7_stall_cycles", st, 35);
      check("divu100_7_starts", sc, 1);
      check("divu100_7_lo", bus.lo, 32'd14);
      check("divu100_7_hi", bus.hi, 32'd2);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, st, sc);
      @(negedge clk);
      check("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);
      check("div_m7_2_dividend", bus.div_dividend, 32'd7);
      check("div_m7_2_divisor", bus.div_divisor, 32'd2);

      run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, st, sc);
      @(negedge clk);
      check("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_7_m2_hi", bus.hi, 32'd1);

      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, st, sc);
      @(negedge clk);
      check("div_min_m1_lo", bus.lo, 32'h8000_0000);
      check("div_min_m1_hi", bus.hi, 32'd0);
      check("div_min_m1_dividend", bus.div_dividend, 32'h8000_0000);
      check("div_min_m1_divisor", bus.div_divisor, 32'd1);

      run_op(OP_DIVU, 32'd5, 32'd0, 0, st, sc);
      @(negedge clk);
      check("divu5_0_lo", bus.lo, 32'hFFFF_FFFF);
      check("divu5_0_hi", bus.hi, 32'd5);

      run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, st, sc);
      @(negedge clk);
      check("mult_stall_cycles", st, 0);
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFFE);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, st, sc);
      @(negedge clk);
      check("multu_stall_cycles", st, 0);
      check("multu_hi", bus.hi, 32'd1);
      check("multu_lo", bus.lo, 32'hFFFF_FFFE);

      run_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 0, st, sc);
      @(negedge clk);
      check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
      check("mthi_lo_kept", bus.lo, 32'hFFFF_FFFE);
      run_op(OP_MTLO, 32'h5A5A_5A5A, 32'd0, 0, st, sc);
      @(negedge clk);
      check("mtlo_lo", bus.lo, 32'h5A5A_5A5A);
      check("mtlo_hi_kept", bus.hi, 32'hA5A5_A5A5);

      run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1, st, sc);
      @(negedge clk);
      check("div_ignore_stall_cycles", st, 35);
      check("div_ignore_starts", sc, 1);
      check("div_ignore_lo", bus.lo, 32'hFFFF_FFF2);
      check("div_ignore_hi", bus.hi, 32'd2);

      div_en = 1'b0;
      run_op(OP_DIVU, 32'd20, 32'd3, 2, st, sc);
      @(negedge clk);
      check("abort_stall_cycles", st, 6);
      check("abort_starts", sc, 1);
      check("abort_stall_after", {31'd0, bus.stall}, 32'd0);
      check("abort_hi_kept", bus.hi, 32'd2);
      check("abort_lo_kept", bus.lo, 32'hFFFF_FFF2);
      div_en = 1'b1;

      run_op(OP_DIV, 32'd100, 32'd7, 3, st, sc);
      @(negedge clk);
      check("midrst_stall", {31'd0, bus.stall}, 32'd0);
      check("midrst_hi", bus.hi, 32'd0);
      check("midrst_lo", bus.lo, 32'd0);

      run_op(OP_DIVU, 32'd9, 32'd3, 0, st, sc);
      @(negedge clk);
      check("divu9_3_starts", sc, 1);
      check("divu9_3_lo", bus.lo, 32'd3);
      check("divu9_3_hi", bus.hi, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
